// File: rtl/serial_arbiter.sv
// serial_arbiter: round-robin arbiter that feeds bytes from N requesters into one transmitter.
// Optional per-requester grant hold is built when SERIAL_ARBITER_LOCK_EN is defined.
module serial_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] dat,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   gnt,
    output logic           tx_stb,
    output logic [7:0]     tx_dat,
    input  logic           tx_rdy,
    output logic [15:0]    cnt
`ifdef SERIAL_ARBITER_LOCK_EN
   ,input  logic [N-1:0]   lock
`endif
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [IW-1:0] owner_r;
    logic [IW-1:0] next_owner_s;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] next_ptr_s;
    logic [15:0]   cnt_r;
    logic [15:0]   next_cnt_s;
    logic [IW-1:0] sel_idx_s;
    logic          sel_found_s;
    logic          owner_req_s;
    logic          hold_s;
    logic [N-1:0]  owner_onehot_s;

    assign owner_req_s    = req[owner_r];
    assign owner_onehot_s = {{(N-1){1'b0}}, 1'b1} << owner_r;
    assign cnt            = cnt_r;

`ifdef SERIAL_ARBITER_LOCK_EN
    assign hold_s = lock[owner_r] & owner_req_s;
`else
    assign hold_s = 1'b0;
`endif

    // Round-robin pick: walking the offsets downward leaves the nearest requester at or after ptr_r.
    always_comb begin
        sel_found_s = |req;
        sel_idx_s   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sel_idx_s = req[(int'(ptr_r) + k) % N] ? IW'((int'(ptr_r) + k) % N) : sel_idx_s;
        end
    end

    // Next-state and output decode; ack/tx_stb/tx_dat follow the live inputs in ISSUE.
    always_comb begin
        next_state_s = state_r;
        next_owner_s = owner_r;
        next_ptr_s   = ptr_r;
        next_cnt_s   = cnt_r;
        ack          = '0;
        gnt          = '0;
        tx_stb       = 1'b0;
        tx_dat       = 8'h00;
        case (state_r)
            IDLE: begin
                if (sel_found_s) begin
                    next_owner_s = sel_idx_s;
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                gnt    = owner_onehot_s;
                tx_stb = owner_req_s;
                tx_dat = dat[{owner_r, 3'b000} +: 8];
                if (!owner_req_s) begin
                    next_state_s = IDLE;
                end else if (tx_rdy) begin
                    ack          = owner_onehot_s;
                    next_cnt_s   = cnt_r + 16'd1;
                    next_ptr_s   = (owner_r == IW'(N - 1)) ? '0 : owner_r + IW'(1);
                    next_state_s = WAIT;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            WAIT: begin
                gnt = owner_onehot_s;
                if (tx_rdy) begin
                    next_state_s = hold_s ? ISSUE : IDLE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, owner, pointer and byte counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            owner_r <= '0;
            ptr_r   <= '0;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= next_state_s;
            owner_r <= next_owner_s;
            ptr_r   <= next_ptr_s;
            cnt_r   <= next_cnt_s;
        end
    end

endmodule

// File: tb/tb_serial_arbiter.sv
// Self-checking bench for serial_arbiter: directed scenarios plus random traffic checked
// against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_serial_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] dat = '0;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic           tx_stb;
    logic [7:0]     tx_dat;
    logic           tx_rdy = 1'b0;
    logic [15:0]    cnt;
`ifdef SERIAL_ARBITER_LOCK_EN
    logic [N-1:0]   lock = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int       got;
    int       zero_acks;
    int       exp_order [4];
    int       lens [N];
    int       rem  [N];
    int       pos  [N];
    logic [7:0] bytes [N][8];
    int       exp_q [$];
    int       mp;
    int       total;
    int       acked;
    int       exp_i;
    int       i2;
    logic     prev_ack;

    always #5 clk = ~clk;

    serial_arbiter #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .dat    (dat),
        .ack    (ack),
        .gnt    (gnt),
        .tx_stb (tx_stb),
        .tx_dat (tx_dat),
        .tx_rdy (tx_rdy),
        .cnt    (cnt)
`ifdef SERIAL_ARBITER_LOCK_EN
       ,.lock   (lock)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dat(input int i, input logic [7:0] b);
        dat[8*i +: 8] = b;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst    = 1'b0;
        req    = '0;
        tx_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state, with a request present that must be ignored
        repeat (2) @(negedge clk);
        req = 4'b0001;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_stb", 32'(tx_stb), 32'h0);
        check("rst_txdat", 32'(tx_dat), 32'h0);
        check("rst_cnt", 32'(cnt), 32'h0);
        @(negedge clk);
        req = '0;
        rst = 1'b1;

        // Single requester 2, one-cycle arbitration latency
        @(negedge clk);
        req = 4'b0100;
        set_dat(2, 8'hA5);
        tx_rdy = 1'b1;
        #1;
        check("t1_idle_stb", 32'(tx_stb), 32'h0);
        @(negedge clk); #1;
        check("t1_stb", 32'(tx_stb), 32'h1);
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_ack", 32'(ack), 32'h4);
        check("t1_txdat", 32'(tx_dat), 32'hA5);
        @(negedge clk);
        req = '0;
        #1;
        check("t1_wait_stb", 32'(tx_stb), 32'h0);
        check("t1_wait_ack", 32'(ack), 32'h0);
        check("t1_wait_gnt", 32'(gnt), 32'h4);
        check("t1_cnt", 32'(cnt), 32'h1);
        @(negedge clk); #1;
        check("t1_idle_gnt", 32'(gnt), 32'h0);

        // Withdrawal of requester 1 in ISSUE while tx_rdy is low
        @(negedge clk);
        tx_rdy = 1'b0;
        req    = 4'b0010;
        set_dat(1, 8'h3C);
        #1;
        @(negedge clk); #1;
        check("t2_stb", 32'(tx_stb), 32'h1);
        check("t2_gnt", 32'(gnt), 32'h2);
        check("t2_txdat", 32'(tx_dat), 32'h3C);
        @(negedge clk);
        req = '0;
        #1;
        check("t2_wd_ack", 32'(ack), 32'h0);
        @(negedge clk); #1;
        check("t2_after_stb", 32'(tx_stb), 32'h0);
        check("t2_after_gnt", 32'(gnt), 32'h0);
        check("t2_after_cnt", 32'(cnt), 32'h1);
        // Pointer must still be 3 after the withdrawal: 0 wins over 2
        @(negedge clk);
        req = 4'b0101;
        #1;
        @(negedge clk); #1;
        check("t2_ptr_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        req = '0;
        @(negedge clk); #1;
        check("t2b_gnt", 32'(gnt), 32'h0);

        // Fairness: all four requesting, eight bytes in rotation
        reset_pulse();
        req    = 4'b1111;
        dat    = {8'h44, 8'h33, 8'h22, 8'h11};
        tx_rdy = 1'b1;
        got    = 0;
        for (int c = 0; c < 100 && got < 8; c++) begin
            @(negedge clk); #1;
            if (ack != '0) begin
                check($sformatf("fair_ack%0d", got), 32'(ack), 32'(1 << (got % 4)));
                check($sformatf("fair_dat%0d", got), 32'(tx_dat), 32'((got % 4 + 1) * 17));
                got++;
            end
        end
        @(negedge clk);
        req = '0;
        #1;
        check("fair_count", 32'(got), 32'd8);
        check("fair_cnt", 32'(cnt), 32'd8);

        // Asynchronous reset in WAIT, then arbitration restarts from pointer 0
        @(negedge clk);
        req = 4'b0100;
        set_dat(2, 8'h5A);
        @(negedge clk); #1;
        check("t4_ack", 32'(ack), 32'h4);
        @(negedge clk);
        req    = '0;
        tx_rdy = 1'b0;
        @(negedge clk); #1;
        check("t4_wait_gnt", 32'(gnt), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check("t4_arst_gnt", 32'(gnt), 32'h0);
        check("t4_arst_stb", 32'(tx_stb), 32'h0);
        check("t4_arst_ack", 32'(ack), 32'h0);
        check("t4_arst_txdat", 32'(tx_dat), 32'h0);
        check("t4_arst_cnt", 32'(cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1010;
        @(negedge clk); #1;
        check("t4_ptr0_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk); #1;
        check("t4_req3_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        req = '0;

        // Lock hold on requester 0 for three bytes
`ifdef SERIAL_ARBITER_LOCK_EN
        exp_order = '{0, 0, 0, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        reset_pulse();
        req = 4'b0011;
        set_dat(0, 8'hA0);
        set_dat(1, 8'hB1);
        tx_rdy    = 1'b1;
        got       = 0;
        zero_acks = 0;
`ifdef SERIAL_ARBITER_LOCK_EN
        lock = 4'b0001;
`endif
        for (int c = 0; c < 100 && got < 4; c++) begin
            @(negedge clk);
`ifdef SERIAL_ARBITER_LOCK_EN
            if (zero_acks >= 3) lock = '0;
`endif
            #1;
            if (ack != '0) begin
                check($sformatf("lock_ack%0d", got), 32'(ack), 32'(1 << exp_order[got]));
                if (ack == 4'b0001) zero_acks++;
                got++;
            end
        end
        @(negedge clk);
        req = '0;
        check("lock_count", 32'(got), 32'd4);

        // Random traffic against the round-robin model
        reset_pulse();
        mp = 0;
        for (int r = 0; r < 3; r++) begin
            total = 0;
            for (int i = 0; i < N; i++) begin
                lens[i] = $urandom_range(0, 5);
                rem[i]  = lens[i];
                pos[i]  = 0;
                total  += lens[i];
                for (int k = 0; k < 8; k++) bytes[i][k] = 8'($urandom);
            end
            exp_q.delete();
            for (int b = 0; b < total; b++) begin
                for (int k = 0; k < N; k++) begin
                    i2 = (mp + k) % N;
                    if (rem[i2] > 0) begin
                        exp_q.push_back(i2);
                        rem[i2]--;
                        mp = (i2 + 1) % N;
                        break;
                    end
                end
            end
            acked    = 0;
            prev_ack = 1'b0;
            for (int c = 0; c < 2000 && acked < total; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    req[i] = (pos[i] < lens[i]);
                    dat[8*i +: 8] = (pos[i] < lens[i]) ? bytes[i][pos[i]] : 8'h00;
                end
                tx_rdy = ($urandom_range(0, 9) < 6);
                #1;
                if (prev_ack) check("rnd_wait_stb", 32'(tx_stb), 32'h0);
                if (ack != '0) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_extra_ack", 32'(ack), 32'h0);
                    end else begin
                        exp_i = exp_q.pop_front();
                        check($sformatf("rnd%0d_ack%0d", r, acked), 32'(ack), 32'(1 << exp_i));
                        check($sformatf("rnd%0d_dat%0d", r, acked), 32'(tx_dat), 32'(bytes[exp_i][pos[exp_i]]));
                        pos[exp_i]++;
                    end
                    acked++;
                end
                prev_ack = (ack != '0);
            end
            @(negedge clk);
            req = '0;
            #1;
            check($sformatf("rnd%0d_done", r), 32'(acked), 32'(total));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  N  per-requester byte request; bit i belongs to requester i.
REQ-005 SHALL have port dat  input  8*N  per-requester byte; bits [8i+7:8i] belong to requester i.
REQ-006 SHALL have port ack  output  N  one-cycle pulse to requester i when its byte is accepted by the transmitter.
REQ-007 SHALL have port gnt  output  N  one-hot current owner; all zero when none.
REQ-008 SHALL have port tx_stb  output  1  strobe to transmit stb.
REQ-009 SHALL have port tx_dat  output  8  byte to transmit dat.
REQ-010 SHALL have port tx_rdy  input  1  transmit rdy; a byte is accepted in any cycle with tx_stb=1 and tx_rdy=1.
REQ-011 SHALL have port cnt  output  16  count of bytes accepted since reset.
REQ-012 SHALL have port lock  input  N  per-requester grant hold, present only when SERIAL_ARBITER_LOCK_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-014 IDLE: if any req bit set, SHALL select the owner round-robin, searching ascending from pointer with wrap N-1 to 0, set gnt one-hot, go to ISSUE next cycle; otherwise stay in IDLE, gnt=0.
REQ-015 ISSUE: SHALL drive tx_stb=1 and tx_dat=owner's dat combinationally from the current inputs.
REQ-016 ISSUE with tx_rdy=1 and owner req=1: SHALL pulse ack[owner] that same cycle, increment cnt, set pointer=(owner+1) mod N, go to WAIT.
REQ-017 ISSUE with owner req=0 (withdrawal): SHALL deassert tx_stb, clear gnt, leave cnt and pointer unchanged, return to IDLE; no ack.
REQ-018 WAIT: SHALL keep tx_stb=0, remain in WAIT for at least one cycle, and exit on the first cycle with tx_rdy=1.
REQ-019 On WAIT exit without a lock hold, SHALL clear gnt and go to IDLE.
REQ-020 Requester data SHALL be stable while req is high until its ack; the arbiter does not latch dat.
REQ-021 Arbitration latency SHALL be one cycle from req rising in IDLE to tx_stb rising.
REQ-022 Requests arriving while another owner holds gnt SHALL wait; no preemption.
REQ-023 cnt SHALL wrap from 16'hFFFF to 0.
REQ-024 Exactly one or zero bits of gnt and of ack SHALL be set in any cycle.

Reset
REQ-025 rst low SHALL immediately force state=IDLE, gnt=0, ack=0, tx_stb=0, tx_dat=0, cnt=0, pointer=0, regardless of clk.
REQ-026 Reset mid-ISSUE or mid-WAIT SHALL abandon the grant without ack; the first request after release SHALL be arbitrated from pointer 0.

Configuration
REQ-027 With SERIAL_ARBITER_LOCK_EN defined, a WAIT exit with lock[owner]=1 and req[owner]=1 SHALL go directly to ISSUE with the same owner, so the pointer does not advance arbitration.
REQ-028 With SERIAL_ARBITER_LOCK_EN defined, lock[owner]=0 or req[owner]=0 at WAIT exit SHALL behave as REQ-019.
REQ-029 Without SERIAL_ARBITER_LOCK_EN, the lock port SHALL be absent and every byte SHALL be re-arbitrated.

Verification
REQ-030 Single requester: req[2]=1, dat=8'hA5, tx_rdy=1 -> tx_stb high one cycle later, ack[2] one pulse, tx_dat=8'hA5, cnt=1.
REQ-031 Fairness: req=4'b1111 held, each requester gets 2 bytes -> grant order 0,1,2,3,0,1,2,3; cnt=8.
REQ-032 Withdrawal: req[1] dropped in ISSUE while tx_rdy=0 -> tx_stb low next cycle, no ack, cnt unchanged, IDLE.
REQ-033 Async reset: rst low mid-WAIT -> outputs zero with no clk edge; next req[3] gets gnt=4'b1000 from pointer 0.
REQ-034 Lock: with SERIAL_ARBITER_LOCK_EN defined, lock[0]=1 with req=4'b0011 for 3 bytes -> 3 consecutive acks to 0, then requester 1; without the macro -> alternating 0,1,0,1.
REQ-035 Loopback with receive and transmit at 12 MHz / 9600 baud: 8 random bytes from 4 requesters -> received bytes equal sent bytes in grant order, and err=0 throughout.
